// File: rtl/MemoryBus.sv
// MemoryBus: command/result types shared by every bus slave.
package MemoryBus;
  typedef struct packed {
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;
  typedef logic [31:0] Result;
endpackage

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: register offsets, status bit positions and receiver states.
package uart_rx_pkg;
  localparam logic [1:0] UART_RX_DATA   = 2'd0;
  localparam logic [1:0] UART_RX_STATUS = 2'd1;
  localparam logic [1:0] UART_RX_CTRL   = 2'd2;
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_BUSY      = 4;
  localparam int ST_COUNT_LSB = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx_slave_sync_fifo.sv
// sync_fifo: power-of-two ring buffer with combinational head output.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0] r_count;
  logic w_pop, w_push;
  assign empty = r_count == '0;
  assign full = r_count == (AW+1)'(DEPTH);
  assign count = r_count;
  assign dout = r_mem[r_rd];
  assign w_pop = pop && !empty;
  // a pop frees the head slot, so a push into a full FIFO is still accepted
  assign w_push = push && (!full || w_pop);
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/uart_rx_slave.sv
// uart_rx_slave: 8N1 serial receiver with FIFO, exposed as a 4-word MemoryBus slave.
module uart_rx_slave
  import MemoryBus::*;
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter int DEFAULT_DIVISOR = 868
) (
  input  logic  clk,
  input  logic  rst,
  input  Cmd    membuscmd,
  output Result membusres,
  input  logic  rx,
  output logic  rx_pending
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);
  logic r_rx_meta, r_rxs;
  rx_state_t r_state;
  logic [DIV_WIDTH-1:0] r_div, r_eff, r_cnt, w_eff_div;
  logic [2:0] r_bit;
  logic [7:0] r_shift, w_dout;
  logic r_overrun, r_frame_err;
  logic [1:0] w_addr;
  logic w_tick, w_push, w_pop, w_empty, w_full, w_stat_wr, w_ctrl_wr, w_unused;
  logic [AW:0] w_count;
  logic [15:0] w_div16, w_div_new;
  logic [31:0] w_status;
  assign w_addr = membuscmd.address[1:0];
  assign w_eff_div = (r_div < MIN_DIV) ? MIN_DIV : r_div;
  assign w_tick = r_cnt == '0;
  assign w_push = r_state == STOP && w_tick && r_rxs;
  assign w_pop = membuscmd.mem_read && w_addr == UART_RX_DATA && !w_empty;
  assign w_stat_wr = membuscmd.mem_write && w_addr == UART_RX_STATUS && membuscmd.mask_byte[0];
  assign w_ctrl_wr = membuscmd.mem_write && w_addr == UART_RX_CTRL;
  assign w_div16 = 16'(r_div);
  assign w_div_new = {membuscmd.mask_byte[1] ? membuscmd.write_data[15:8] : w_div16[15:8],
                      membuscmd.mask_byte[0] ? membuscmd.write_data[7:0] : w_div16[7:0]};
  assign w_unused = ^{membuscmd.address[31:2], membuscmd.mask_byte[3:2], membuscmd.write_data[31:16]};
  assign rx_pending = !w_empty;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(w_push), .din(r_shift), .pop(w_pop),
    .dout(w_dout), .empty(w_empty), .full(w_full), .count(w_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs <= 1'b1;
      r_state <= IDLE;
      r_cnt <= '0;
      r_eff <= MIN_DIV;
      r_bit <= '0;
      r_shift <= '0;
    end else begin
      r_rx_meta <= rx;
      r_rxs <= r_rx_meta;
      case (r_state)
        IDLE: if (!r_rxs) begin
          r_state <= START;
          r_eff <= w_eff_div;
          r_cnt <= (w_eff_div >> 1) - ONE;
        end
        START: if (!w_tick) r_cnt <= r_cnt - ONE;
          else if (r_rxs) r_state <= IDLE;
          else begin
            r_state <= DATA;
            r_cnt <= r_eff - ONE;
            r_bit <= '0;
          end
        DATA: if (!w_tick) r_cnt <= r_cnt - ONE;
          else begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_cnt <= r_eff - ONE;
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= STOP;
          end
        STOP: if (!w_tick) r_cnt <= r_cnt - ONE;
          else r_state <= IDLE;
      endcase
    end
  end
  // set events take priority over write-1-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
      r_frame_err <= 1'b0;
      r_div <= DIV_WIDTH'(DEFAULT_DIVISOR);
    end else begin
      r_overrun <= (w_push && w_full && !w_pop) ||
                   (r_overrun && !(w_stat_wr && membuscmd.write_data[ST_OVERRUN]));
      r_frame_err <= (r_state == STOP && w_tick && !r_rxs) ||
                     (r_frame_err && !(w_stat_wr && membuscmd.write_data[ST_FRAME_ERR]));
      if (w_ctrl_wr) r_div <= DIV_WIDTH'(w_div_new);
    end
  end
  always_comb begin
    w_status = '0;
    w_status[ST_COUNT_LSB +: 8] = 8'(w_count);
    w_status[ST_BUSY] = r_state != IDLE;
    w_status[ST_FRAME_ERR] = r_frame_err;
    w_status[ST_OVERRUN] = r_overrun;
    w_status[ST_FULL] = w_full;
    w_status[ST_EMPTY] = w_empty;
    membusres = w_addr == UART_RX_DATA ? (w_empty ? 32'h0 : {23'h0, 1'b1, w_dout}) :
                w_addr == UART_RX_STATUS ? w_status :
                w_addr == UART_RX_CTRL ? 32'(r_div) : 32'h0;
  end
endmodule

// File: tb/tb_uart_rx_slave.sv
// tb_uart_rx_slave: directed and randomized frames checked against a queue-based receiver model.
module tb_uart_rx_slave;
  import MemoryBus::*;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_pending;
  Cmd cmd;
  Result res;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  logic ov = 1'b0, fe = 1'b0;
  always #5 clk = ~clk;
  uart_rx_slave #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .DEFAULT_DIVISOR(868)) dut (
    .clk(clk), .rst(rst), .membuscmd(cmd), .membusres(res), .rx(rx), .rx_pending(rx_pending)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_stat();
    return {16'h0, 8'(q.size()), 3'b0, 1'b0, fe, ov, q.size() == DEPTH, q.size() == 0};
  endfunction
  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    cmd.address = {30'h0, a};
    cmd.mem_read = 1'b1;
    #1 d = res;
    @(posedge clk);
    #1 cmd.mem_read = 1'b0;
  endtask
  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    cmd.address = {30'h0, a};
    cmd.write_data = d;
    cmd.mask_byte = m;
    cmd.mem_write = 1'b1;
    @(posedge clk);
    #1 cmd.mem_write = 1'b0;
  endtask
  task automatic send(input logic [7:0] d, input bit ok, input int div, input int gap);
    @(negedge clk);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (div) @(negedge clk);
    end
    rx = ok;
    repeat (div) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask
  task automatic model(input logic [7:0] d, input bit ok);
    if (!ok) fe = 1'b1;
    else if (q.size() < DEPTH) q.push_back(d);
    else ov = 1'b1;
  endtask
  task automatic chk_stat(input string tag);
    logic [31:0] v;
    bus_rd(2'd1, v);
    chk(tag, v, exp_stat());
    chk({tag, "_pend"}, 32'(rx_pending), 32'(q.size() != 0));
  endtask
  task automatic pop_chk(input string tag);
    logic [31:0] v, e;
    bus_rd(2'd0, v);
    e = q.size() != 0 ? {23'h0, 1'b1, q[0]} : 32'h0;
    if (q.size() != 0) void'(q.pop_front());
    chk(tag, v, e);
  endtask
  initial begin
    logic [31:0] v, hv;
    logic [7:0] b;
    int dv, eff;
    bit ok;
    cmd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk_stat("reset_status");
    bus_rd(2'd2, v);
    chk("reset_ctrl", v, 32'd868);
    bus_rd(2'd0, v);
    chk("reset_data", v, 32'h0);
    bus_wr(2'd2, 32'h4, 4'b0011);
    send(8'hA5, 1'b1, 4, 6); model(8'hA5, 1'b1);
    chk_stat("a5_status");
    pop_chk("a5_data");
    chk_stat("a5_after_pop");
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), 1'b1, 4, 0);
      model(8'(i), 1'b1);
    end
    repeat (8) @(negedge clk);
    chk_stat("burst_full_ovr");
    for (int i = 0; i < 8; i++) pop_chk("burst_pop");
    bus_wr(2'd1, 32'h4, 4'b0001); ov = 1'b0;
    chk_stat("ovr_cleared");
    send(8'h3C, 1'b0, 4, 8); model(8'h3C, 1'b0);
    chk_stat("frame_err");
    bus_wr(2'd1, 32'h8, 4'b0010);
    chk_stat("fe_mask_ignored");
    bus_wr(2'd1, 32'h8, 4'b0001); fe = 1'b0;
    chk_stat("fe_cleared");
    send(8'h3C, 1'b1, 4, 6); model(8'h3C, 1'b1);
    pop_chk("3c_data");
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    @(negedge clk);
    bus_rd(2'd1, v);
    chk("glitch_busy", v, 32'h11);
    repeat (4) @(negedge clk);
    chk_stat("glitch_idle");
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i), 1'b1, 4, 6);
      model(8'h10 + 8'(i), 1'b1);
    end
    chk_stat("prefill_full");
    fork
      send(8'h55, 1'b1, 4, 6);
      begin
        @(negedge clk);
        repeat (40) @(negedge clk);
        cmd.address = 32'h0;
        cmd.mem_read = 1'b1;
        #1 hv = res;
        @(posedge clk);
        #1 cmd.mem_read = 1'b0;
      end
    join
    chk("aligned_head", hv, {23'h0, 1'b1, q[0]});
    void'(q.pop_front());
    model(8'h55, 1'b1);
    chk_stat("aligned_status");
    for (int i = 0; i < 5; i++) pop_chk("aligned_drain");
    fork
      send(8'hF5, 1'b1, 4, 8);
      begin
        @(negedge clk);
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        q.delete(); ov = 1'b0; fe = 1'b0;
        chk_stat("rst_mid_status");
        bus_rd(2'd2, v);
        chk("rst_mid_ctrl", v, 32'd868);
      end
    join
    chk_stat("rst_after_frame");
    bus_wr(2'd2, 32'hABCD1234, 4'b0001);
    bus_rd(2'd2, v);
    chk("ctrl_mask_lo", v, 32'h0334);
    bus_wr(2'd2, 32'hFFFFFFFF, 4'b1100);
    bus_rd(2'd2, v);
    chk("ctrl_mask_hi_ignored", v, 32'h0334);
    bus_rd(2'd3, v);
    chk("word3_zero", v, 32'h0);
    for (int k = 0; k < 16; k++) begin
      dv = $urandom_range(2, 9);
      eff = dv < 4 ? 4 : dv;
      b = 8'($urandom);
      ok = $urandom_range(0, 5) != 0;
      bus_wr(2'd2, 32'(dv), 4'b0011);
      send(b, ok, eff, eff + 2);
      model(b, ok);
      chk_stat("rand_status");
      if ($urandom_range(0, 2) == 0) pop_chk("rand_pop");
      if ((fe || ov) && $urandom_range(0, 1) == 1) begin
        bus_wr(2'd1, 32'hC, 4'b0001);
        fe = 1'b0; ov = 1'b0;
      end
    end
    while (q.size() != 0) pop_chk("rand_drain");
    chk_stat("final_status");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_slave.md
Name: uart_rx_slave

Overview:
- MemoryBus slave UART receiver; the input-direction counterpart of the existing write-only UART output port.
- Deserialises an 8N1 serial line into a receive FIFO.
- Exposes data, status and baud-divisor registers to the CPU or probe through a 4-word slot behind SlaveBusMux.
- Drives an interrupt-style level output while data is pending.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; power of two, minimum 2.
- DIV_WIDTH, 16, width of the baud divisor (clocks per bit).
- DEFAULT_DIVISOR, 868, divisor value loaded at reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- membuscmd  in  MemoryBus::Cmd  bus command; uses address[1:0] as word offset, mem_read, mem_write, mask_byte, write_data
- membusres  out  MemoryBus::Result (32)  read data, combinational from address
- rx  in  1  serial line, idle high, asynchronous to clk
- rx_pending  out  1  high while the FIFO is non-empty

Behaviour:
- Reset values:
  - rx synchroniser both stages = 1; FSM = IDLE; FIFO empty; overrun = 0; frame_err = 0; divisor = DEFAULT_DIVISOR; rx_pending = 0.
  - membusres reflects register contents only, so with empty FIFO it reads 0 at word 0.
  - Reset mid-frame discards the partial byte and the FIFO contents.
- Input: rx passes a 2-FF synchroniser; only the synchronised signal (rxs) is used.
- Divisor handling: the effective divisor is latched at start detection. Values below 4 are treated as 4. Divisor writes mid-frame affect the next frame only.
- FSM:
  - IDLE: rxs=0 -> START; load bit counter with eff_div/2 - 1.
  - START: at counter 0, sample rxs.
    - 0 -> DATA; counter = eff_div - 1; bit index = 0.
    - 1 -> IDLE (glitch rejected, no flag set).
  - DATA: at each counter 0, shift rxs into the shift register LSB-first and reload the counter. After bit 7 -> STOP with counter = eff_div - 1.
  - STOP: at counter 0, sample rxs.
    - 1: push the byte. If the FIFO is full and no pop happens this cycle, drop the byte and set overrun.
    - 0: discard the byte and set frame_err.
    - Either way -> IDLE the same cycle.
    - A held-low line (break) re-enters START immediately; each break frame sets frame_err again.
- Register map, word offset = address[1:0]:
  - 0 DATA, read-only:
    - Read value = {23'b0, !empty, head[7:0]}.
    - A read with mem_read=1 and FIFO non-empty pops the FIFO at the clock edge.
    - A read of an empty FIFO returns 0 and has no side effect.
    - Writes ignored.
  - 1 STATUS:
    - Read value = {16'b0, count[7:0], 3'b0, busy, frame_err, overrun, full, empty}; busy = FSM != IDLE.
    - Write with mask_byte[0]=1: write_data[2]=1 clears overrun and write_data[3]=1 clears frame_err (write-1-to-clear).
    - A set event and a clear in the same cycle leaves the flag set.
  - 2 CTRL:
    - Read value = zero-extended divisor.
    - Write updates divisor bytes gated by mask_byte[0] and mask_byte[1]; upper mask bits ignored.
  - 3: reads 0, writes ignored.
- Simultaneous push and pop, including when full: both occur and count is unchanged; no overrun is set.
- Pop when count=1 with a same-cycle push: the FIFO holds the new byte.
- Read and write in the same command are processed independently.
- Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- rx_pending = !empty, combinational.

Decomposition:
- MemoryBus package (existing) supplies Cmd/Result.
- Add uart_rx_pkg holding:
  - register offset constants: UART_RX_DATA=0, UART_RX_STATUS=1, UART_RX_CTRL=2;
  - STATUS bit-position constants;
  - the FSM enum rx_state_t {IDLE, START, DATA, STOP}.
- One sub-module: sync_fifo.
  - Parameters: WIDTH=8, DEPTH.
  - Ports: clk, rst, push, din, pop, dout, empty, full, count.
  - dout is combinational from the head entry.
- The top module holds the synchroniser, FSM, divisor and register decode.

Test Plan:
- Reset, then program CTRL=4 (mask 4'b0011), send 0xA5 at 4 clk/bit -> after about 40 clocks STATUS reads 0x0100 with empty=0 and rx_pending=1; a DATA read returns 0x1A5; the next cycle STATUS=0x0001 and rx_pending=0.
- Divisor 4, send 9 back-to-back bytes 0x01..0x09 with no reads (FIFO_DEPTH=8) -> count=8, full=1, overrun=1; 0x09 is lost; 8 pops return 0x101..0x108; writing STATUS 0x4 clears overrun.
- Stop bit driven 0 on byte 0x3C -> frame_err=1, count stays 0; writing STATUS 0x8 clears it; a following valid 0x3C is received correctly.
- 1-clock low glitch on rx while idle -> START aborts at mid-bit; no push, no flags; busy returns to 0 within eff_div/2+2 clocks.
- FIFO full, with the STOP push aligned to a DATA read in the same cycle -> head popped and new byte appended; count stays 8; overrun stays 0.
- Assert rst during DATA bit 4 of a frame with 3 bytes queued -> next cycle STATUS=0x0001, CTRL=868, rx_pending=0; the remainder of the aborted frame is not captured as a byte.
